// File: rtl/dac_spi_writer_pkg.sv
// dac_spi_writer_pkg
//   Shared definitions for the DAC SPI writer: FSM state type, default
//   frame width / bit-counter width and a small constant helper.
package dac_spi_writer_pkg;

  localparam int unsigned DAC_DATA_WIDTH = 16;
  localparam int unsigned DAC_CNT_WIDTH  = $clog2(DAC_DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } dac_state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dac_spi_writer_if.sv
// dac_spi_writer_if
//   Sample handshake between the producer (DSP/control logic) and the DAC
//   SPI writer.
//   dac_valid / dac_data : producer -> writer, word offered for transmission
//   dac_ready            : writer -> producer, word accepted on valid&&ready
//   dac_busy             : writer -> producer, frame in progress
//   dac_done             : writer -> producer, one-cycle end-of-frame pulse
//   master modport = producer side, slave modport = writer side.
interface dac_spi_writer_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic                  dac_valid;
  logic [DATA_WIDTH-1:0] dac_data;
  logic                  dac_ready;
  logic                  dac_busy;
  logic                  dac_done;

  modport master (output dac_valid, dac_data, input dac_ready, dac_busy, dac_done);
  modport slave  (input dac_valid, dac_data, output dac_ready, dac_busy, dac_done);
endinterface

// File: rtl/dac_spi_writer_sclk_divider.sv
// dac_spi_writer_sclk_divider
//   Serial-clock generator. While en is high it counts CLK_DIV system clocks
//   per half-period and toggles a registered sclk, starting low. fall is a
//   one-cycle enable coinciding with the clock edge on which sclk drops.
//   Dropping en forces sclk low and restarts the count.
//   Ports: clk, rstn (async active low), en, sclk, fall.
module dac_spi_writer_sclk_divider #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic sclk,
  output logic fall
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = en && (cnt == TC);
  assign fall = tick && sclk;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dac_spi_writer.sv
// dac_spi_writer
//   SPI mode-0, MSB-first master writing parallel samples to a serial DAC.
//   One word is taken per valid/ready handshake; frame is
//   SETUP (CS_SETUP) -> SHIFT (DATA_WIDTH bits of 2*CLK_DIV cycles)
//   -> HOLD (CS_HOLD) -> GAP (idle gap) -> IDLE.
//   Ports: clk, rstn (async active low), dac (handshake, slave modport),
//          dac_csn, dac_sclk, dac_sdi (DAC pins, all registered),
//          dac_ldacn (load strobe, only when DAC_LDAC_EN is defined).
//   Build option DAC_LDAC_EN: adds a 2-cycle active-low LDAC pulse after csn
//   rises and stretches the idle gap to at least 2 cycles.
module dac_spi_writer
  import dac_spi_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DAC_DATA_WIDTH,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_SETUP   = 1,
  parameter int unsigned CS_HOLD    = 1,
  parameter int unsigned IDLE_GAP   = 2
) (
  input  logic             clk,
  input  logic             rstn,
  dac_spi_writer_if.slave  dac,
  output logic             dac_csn,
  output logic             dac_sclk,
  output logic             dac_sdi
`ifdef DAC_LDAC_EN
  ,
  output logic             dac_ldacn
`endif
);

`ifdef DAC_LDAC_EN
  localparam int unsigned GAP_LEN = max2(IDLE_GAP, 2);
`else
  localparam int unsigned GAP_LEN = IDLE_GAP;
`endif
  localparam int unsigned PH_MAX = max2(max2(CS_SETUP, CS_HOLD), max2(GAP_LEN, 1));
  localparam int unsigned PW     = $clog2(PH_MAX + 1);
  localparam int unsigned BW     = $clog2(DATA_WIDTH + 1);

  dac_state_t            state, state_n;
  logic [PW-1:0]         ph_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] sr;
  logic                  ready_q, done_q, csn_q;
  logic                  accept, sclk_fall, last_fall, hold_exit;

  dac_spi_writer_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rstn (rstn),
    .en   (state == ST_SHIFT),
    .sclk (dac_sclk),
    .fall (sclk_fall)
  );

  assign accept    = dac.dac_valid && ready_q;
  assign last_fall = (state == ST_SHIFT) && sclk_fall && (bit_cnt == BW'(DATA_WIDTH - 1));
  assign hold_exit = (state == ST_HOLD) && (ph_cnt == PW'(CS_HOLD - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (accept) state_n = ST_SETUP;
      ST_SETUP: if (ph_cnt == PW'(CS_SETUP - 1)) state_n = ST_SHIFT;
      ST_SHIFT: if (last_fall) state_n = ST_HOLD;
      ST_HOLD:  if (hold_exit) state_n = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:   if (ph_cnt == PW'(GAP_LEN - 1)) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // ready/csn are registered from the next state so they change on the same
  // edge as the state itself and never glitch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      csn_q   <= 1'b1;
    end else begin
      state   <= state_n;
      ready_q <= (state_n == ST_IDLE);
      done_q  <= hold_exit;
      csn_q   <= !((state_n == ST_SETUP) || (state_n == ST_SHIFT) || (state_n == ST_HOLD));

      if ((state_n != state) || (state == ST_IDLE) || (state == ST_SHIFT))
        ph_cnt <= '0;
      else
        ph_cnt <= ph_cnt + PW'(1);

      if (accept)
        bit_cnt <= '0;
      else if ((state == ST_SHIFT) && sclk_fall)
        bit_cnt <= bit_cnt + BW'(1);

      // sdi is the MSB of the shift register; it moves only on sclk falls
      // (not after the last bit, so the LSB is held through HOLD) and is
      // cleared as csn rises so sdi stays low while deselected.
      if (accept)
        sr <= dac.dac_data;
      else if ((state == ST_SHIFT) && sclk_fall && !last_fall)
        sr <= {sr[DATA_WIDTH-2:0], 1'b0};
      else if (hold_exit)
        sr <= '0;
    end
  end

  assign dac.dac_ready = ready_q;
  assign dac.dac_busy  = (state != ST_IDLE);
  assign dac.dac_done  = done_q;
  assign dac_csn       = csn_q;
  assign dac_sdi       = sr[DATA_WIDTH-1];

`ifdef DAC_LDAC_EN
  logic ldac_d;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ldac_d    <= 1'b0;
      dac_ldacn <= 1'b1;
    end else begin
      ldac_d    <= done_q;
      dac_ldacn <= !(done_q || ldac_d);
    end
  end
`endif

endmodule
